// File: rtl/cpu_pkg.sv
// Shared opcode constants, FSM state encoding and control bundle.
// Used by control_unit and control_decode.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // S_PEND is the T0-pending state held during and just after clear.
    typedef enum logic [3:0] {
        S_PEND, S_T0, S_T1, S_T2, S_T3,
        S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef struct packed {
        logic       Run;
        logic       PCout;
        logic       PCin;
        logic       IncPC;
        logic       MARin;
        logic       MDRin;
        logic       MDRout;
        logic       Read;
        logic       Write;
        logic       IRin;
        logic       Yin;
        logic       Zin;
        logic       Zlowout;
        logic       Cout;
        logic       Gra;
        logic       Grb;
        logic       Grc;
        logic       Rin;
        logic       Rout;
        logic       BAout;
        logic [4:0] opcode;
    } ctrl_t;

    function automatic logic is_mem(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    endfunction

    function automatic logic is_alu(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational strobe decode: (state, opcode) -> control bundle.
// Ports: state, op in; ctrl out (all strobes, Run, ALU opcode).
module control_decode
    import cpu_pkg::*;
(
    input  state_t     state,
    input  logic [4:0] op,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        ctrl.Run = (state != S_PEND) && (state != S_HALT);
        case (state)
            S_T0: begin
                ctrl.PCout = 1'b1;
                ctrl.MARin = 1'b1;
                ctrl.IncPC = 1'b1;
                ctrl.Zin   = 1'b1;
            end
            S_T1: begin
                ctrl.Zlowout = 1'b1;
                ctrl.PCin    = 1'b1;
                ctrl.Read    = 1'b1;
                ctrl.MDRin   = 1'b1;
            end
            S_T2: begin
                ctrl.MDRout = 1'b1;
                ctrl.IRin   = 1'b1;
            end
            S_T3: begin
                ctrl.Grb = 1'b1;
                ctrl.Yin = 1'b1;
                // Memory ops use base-address drive so R0 reads as 0.
                if (is_mem(op)) ctrl.BAout = 1'b1;
                else            ctrl.Rout  = 1'b1;
            end
            S_T4: begin
                ctrl.Zin = 1'b1;
                if (is_alu(op)) begin
                    ctrl.Grc    = 1'b1;
                    ctrl.Rout   = 1'b1;
                    ctrl.opcode = op;
                end else begin
                    ctrl.Cout   = 1'b1;
                    ctrl.opcode = OP_ADD;
                end
            end
            S_T5: begin
                ctrl.Zlowout = 1'b1;
                if (op == OP_LD || op == OP_ST) begin
                    ctrl.MARin = 1'b1;
                end else begin
                    ctrl.Gra = 1'b1;
                    ctrl.Rin = 1'b1;
                end
            end
            S_T6: begin
                if (op == OP_LD) begin
                    ctrl.Read  = 1'b1;
                    ctrl.MDRin = 1'b1;
                end else if (op == OP_ST) begin
                    ctrl.Gra   = 1'b1;
                    ctrl.Rout  = 1'b1;
                    ctrl.MDRin = 1'b1;
                end
            end
            S_T7: begin
                if (op == OP_LD) begin
                    ctrl.MDRout = 1'b1;
                    ctrl.Gra    = 1'b1;
                    ctrl.Rin    = 1'b1;
                end else if (op == OP_ST) begin
                    ctrl.Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired T-state sequencer for the bus CPU.
// Ports: Clock, clear, IR, Stop in; Run, datapath strobes, opcode out.
module control_unit
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        Run,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Cout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic [4:0]  opcode
);

    state_t     state, state_nx;
    logic       stop_q;
    logic [4:0] op;
    state_t     fin;
    ctrl_t      ctrl;
    logic       unused_ir;

    assign op        = IR[31:27];
    assign unused_ir = ^IR[26:0];

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state  <= S_PEND;
            stop_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (Stop) stop_q <= 1'b1;
        end
    end

    // A Stop seen in the final cycle still diverts to HALT.
    assign fin = (stop_q || Stop) ? S_HALT : S_T0;

    always_comb begin
        state_nx = state;
        case (state)
            S_PEND: state_nx = S_T0;
            S_T0:   state_nx = S_T1;
            S_T1:   state_nx = S_T2;
            S_T2: begin
                if (op == OP_HALT)
                    state_nx = S_HALT;
                else if (is_mem(op) || is_alu(op) || op == OP_ADDI)
                    state_nx = S_T3;
                else
                    state_nx = fin;
            end
            S_T3:   state_nx = S_T4;
            S_T4:   state_nx = S_T5;
            S_T5: begin
                if (op == OP_LD || op == OP_ST) state_nx = S_T6;
                else                            state_nx = fin;
            end
            S_T6:   state_nx = S_T7;
            S_T7:   state_nx = fin;
            S_HALT: state_nx = S_HALT;
            default: state_nx = S_PEND;
        endcase
    end

    control_decode u_dec (
        .state (state),
        .op    (op),
        .ctrl  (ctrl)
    );

    assign Run     = ctrl.Run;
    assign PCout   = ctrl.PCout;
    assign PCin    = ctrl.PCin;
    assign IncPC   = ctrl.IncPC;
    assign MARin   = ctrl.MARin;
    assign MDRin   = ctrl.MDRin;
    assign MDRout  = ctrl.MDRout;
    assign Read    = ctrl.Read;
    assign Write   = ctrl.Write;
    assign IRin    = ctrl.IRin;
    assign Yin     = ctrl.Yin;
    assign Zin     = ctrl.Zin;
    assign Zlowout = ctrl.Zlowout;
    assign Cout    = ctrl.Cout;
    assign Gra     = ctrl.Gra;
    assign Grb     = ctrl.Grb;
    assign Grc     = ctrl.Grc;
    assign Rin     = ctrl.Rin;
    assign Rout    = ctrl.Rout;
    assign BAout   = ctrl.BAout;
    assign opcode  = ctrl.opcode;

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Clock  input  1  single system clock; all state changes on rising edge.
REQ-002 clear  input  1  asynchronous, active-high reset.
REQ-003 IR  input  32  current instruction register contents; opcode = IR[31:27].
REQ-004 Stop  input  1  halt request; sampled every cycle.
REQ-005 Run  output  1  high while executing; low in HALT and during reset.
REQ-006 PCout, PCin, IncPC  output  1 each  PC drive to bus, PC load from bus, PC increment-mode.
REQ-007 MARin  output  1  MAR load from bus.
REQ-008 MDRin, MDRout  output  1 each  MDR load, MDR drive to bus.
REQ-009 Read, Write  output  1 each  memory read (MDR source = memory), memory write strobe.
REQ-010 IRin  output  1  IR load from bus.
REQ-011 Yin, Zin, Zlowout  output  1 each  Y load, Z load, Z[31:0] drive to bus.
REQ-012 Cout  output  1  sign-extended IR constant drive to bus.
REQ-013 Gra, Grb, Grc  output  1 each  register-field select (Ra/Rb/Rc).
REQ-014 Rin, Rout, BAout  output  1 each  selected-register load, drive, base-address drive (R0 reads as 0).
REQ-015 opcode  output  5  ALU operation select.

Function
REQ-016 Opcodes SHALL be: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, nop 11010, halt 11011; any other value SHALL execute as nop.
REQ-017 States SHALL be T0..T7 and HALT; each T-state SHALL last exactly one Clock cycle; outputs SHALL be Moore decodes of the state register (plus IR[31:27]) and be stable for the whole cycle.
REQ-018 Fetch, all instructions: T0 PCout MARin IncPC Zin; T1 Zlowout PCin Read MDRin; T2 MDRout IRin.
REQ-019 T2->T3 for ld/ldi/st/ALU/addi; T2->T0 for nop; T2->HALT for halt.
REQ-020 ld/ldi/st: T3 Grb BAout Yin; T4 Cout opcode=00011 Zin.
REQ-021 ldi: T5 Zlowout Gra Rin, then T0 (6 cycles total).
REQ-022 ld: T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin, then T0 (8 cycles).
REQ-023 st: T5 Zlowout MARin; T6 Gra Rout MDRin (Read=0); T7 Write, then T0 (8 cycles).
REQ-024 add/sub/and/or: T3 Grb Rout Yin; T4 Grc Rout opcode=IR[31:27] Zin; T5 Zlowout Gra Rin, then T0.
REQ-025 addi: T3 Grb Rout Yin; T4 Cout opcode=00011 Zin; T5 Zlowout Gra Rin, then T0.
REQ-026 opcode SHALL be 00000 in every state not listed above; all unlisted strobes SHALL be 0.
REQ-027 Stop high in any cycle SHALL be latched; the current instruction SHALL complete and the state SHALL enter HALT instead of T0.
REQ-028 HALT SHALL be absorbing (all strobes 0, Run=0) until clear.
REQ-029 At most one of PCout, MDRout, Zlowout, Cout, Rout, BAout SHALL be high in any cycle.

Reset
REQ-030 clear high SHALL immediately force state=T0-pending, Stop latch=0, all strobes 0, opcode=00000, Run=0, including mid-instruction (instruction aborted).
REQ-031 First rising Clock edge after clear falls SHALL enter T0 with Run=1.

Structure
REQ-032 Opcode constants and state encoding SHALL live in shared package cpu_pkg.
REQ-033 Strobe decode MAY be split into one combinational sub-module control_decode (state, opcode -> strobes); the state register stays in control_unit.

Verification
REQ-034 Release clear, IR=0x09000005 (ldi R2,5) -> T0..T5 strobes per REQ-018/020/021, Gra&Rin in cycle 6, T0 in cycle 7.
REQ-035 IR=0x18918000 (add R1,R2,R3) -> T4 opcode=00011 Grc Rout Zin; sub 0x20918000 -> T4 opcode=00100.
REQ-036 IR=0x01000055 (ld R2,0x55) -> 8 cycles, Read in T1 and T6, Gra Rin only in T7; st 0x11000055 -> Write only in T7, Read=0 in T6.
REQ-037 IR=0xD8000000 (halt) -> HALT after T2, Run=0, no strobes for 20 cycles; clear pulse -> T0, Run=1.
REQ-038 Stop pulsed in T4 of add -> T5 completes, then HALT; clear asserted in T6 of ld -> all strobes 0 same cycle, T0 after release.
REQ-039 Every cycle of every scenario -> bus-driver one-hot-or-zero check (REQ-029) passes.
